// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-channel PWM with shared duty cycle and per-channel enable/mode.
// Optional macro PWM_DUTY_SHADOW_EN latches the duty cycle only at period wrap.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;
  logic          wrap_seen;
  logic          tick;
  logic          wrap;
  logic [7:0]    duty;
  logic          pwm_sig;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;

  assign tick   = (prescaler == PRE_MAX);
  assign wrap   = tick && (pwm_cnt == 8'hFF);
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= 8'h00;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'h01;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] shadow_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_duty <= 8'h00;
    else if (wrap) shadow_duty <= pwm_duty_cycle;
  end

  assign duty = shadow_duty;
`else
  assign duty = pwm_duty_cycle;
`endif

  // Full scale is forced high so duty 0xFF never drops low on the last step.
  assign pwm_sig = (duty == 8'hFF) || (pwm_cnt < duty);

  // wrap_seen delays the wrap by one clk so period_start lines up with out showing count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
      wrap_seen    <= 1'b0;
    end else begin
      out          <= en_out & (~en_pwm | {16{pwm_sig}});
      period_start <= wrap_seen;
      wrap_seen    <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - directed vector bench for pwm_peripheral.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PER     = 256 * CLK_DIV;

  typedef struct {
    string       name;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    int          exp_high0;
    logic [15:0] rest_mask;
    logic [15:0] rest_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    eo_lo = eo[7:0];
    eo_hi = eo[15:8];
    ep_lo = ep[7:0];
    ep_hi = ep[15:8];
    duty  = d;
  endtask

  task automatic wait_ps(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < PER + 16; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: period_start timeout, got none, expected one within %0d clks", name, PER + 16);
    end
  endtask

  // Counts clks from the negedge after release until period_start is first seen.
  task automatic ps_latency(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= PER + 8; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        k = i;
        break;
      end
    end
    check(name, k - 1, PER);
  endtask

  vec_t vecs[8];
  int   high0, rest_bad, ps_cnt, bad;

  initial begin
    vecs[0] = '{"static_00ff", 16'h00FF, 16'h0000, 8'h80, PER,       16'hFFFE, 16'h00FE};
    vecs[1] = '{"pwm_50pct",   16'hFFFF, 16'h0001, 8'h80, 1664,      16'hFFFE, 16'hFFFE};
    vecs[2] = '{"duty_00",     16'hFFFF, 16'h0001, 8'h00, 0,         16'hFFFE, 16'hFFFE};
    vecs[3] = '{"duty_ff",     16'hFFFF, 16'h0001, 8'hFF, PER,       16'hFFFE, 16'hFFFE};
    vecs[4] = '{"duty_01",     16'hFFFF, 16'h0001, 8'h01, 13,        16'hFFFE, 16'hFFFE};
    vecs[5] = '{"duty_fe",     16'hFFFF, 16'h0001, 8'hFE, 3302,      16'hFFFE, 16'hFFFE};
    vecs[6] = '{"all_off",     16'h0000, 16'hFFFF, 8'h80, 0,         16'hFFFE, 16'h0000};
    vecs[7] = '{"ch0_off",     16'hFFFE, 16'hFFFF, 8'h40, 0,         16'h0000, 16'h0000};

    // Reset held with every input at 0xFF
    set_in(16'hFFFF, 16'hFFFF, 8'hFF);
    rst_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out !== 16'h0000 || period_start !== 1'b0) bad++;
    end
    check("reset_hold_outputs_low", bad, 0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef PWM_DUTY_SHADOW_EN
    check("out_after_release", out, 16'h0000);
`else
    check("out_after_release", out, 16'hFFFF);
`endif
    begin
      int k;
      k = 1;
      for (int i = 2; i <= PER + 8; i++) begin
        if (period_start === 1'b1) break;
        @(negedge clk);
        k = i;
      end
      check("first_period_start_latency", k - 1, PER);
    end

    foreach (vecs[v]) begin
      set_in(vecs[v].en_out, vecs[v].en_pwm, vecs[v].duty);
      @(negedge clk);
      @(negedge clk);
      wait_ps(vecs[v].name);
      high0 = 0; rest_bad = 0; ps_cnt = 0;
      for (int i = 0; i < PER; i++) begin
        if (i > 0) @(negedge clk);
        high0 += int'(out[0]);
        if ((out & vecs[v].rest_mask) !== vecs[v].rest_val) rest_bad++;
        ps_cnt += int'(period_start);
      end
      check({vecs[v].name, "_high0"}, high0, vecs[v].exp_high0);
      check({vecs[v].name, "_rest"}, rest_bad, 0);
      check({vecs[v].name, "_ps_count"}, ps_cnt, 1);
    end

    // Duty change from 0x40 to 0xC0 at pwm_cnt 0x20
    set_in(16'hFFFF, 16'h0001, 8'h40);
    @(negedge clk);
    wait_ps("shadow_align");
    wait_ps("shadow_align2");
    high0 = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 32 * CLK_DIV) duty = 8'hC0;
      high0 += int'(out[0]);
    end
`ifdef PWM_DUTY_SHADOW_EN
    check("duty_change_cur_period", high0, 64 * CLK_DIV);
`else
    check("duty_change_cur_period", high0, 192 * CLK_DIV);
`endif
    high0 = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      high0 += int'(out[0]);
    end
    check("duty_change_next_period", high0, 192 * CLK_DIV);

    // Asynchronous reset at pwm_cnt 0x90
    set_in(16'hFFFF, 16'h0000, 8'h80);
    wait_ps("midreset_align");
    for (int i = 0; i < 16'h90 * CLK_DIV; i++) @(negedge clk);
    check("out_before_midreset", out, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("out_async_clear", out, 16'h0000);
    check("ps_async_clear", period_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ps_latency("midreset_period_start_latency");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter CLK_DIV, default 13, meaning clk cycles per PWM counter step (legal 1..65535); 10 MHz / (13*256) gives about 3.0 kHz PWM.
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en_reg_out_7_0  input  8  per-channel output enable, channels 7..0.
REQ-005 en_reg_out_15_8  input  8  per-channel output enable, channels 15..8.
REQ-006 en_reg_pwm_7_0  input  8  per-channel PWM mode select, channels 7..0.
REQ-007 en_reg_pwm_15_8  input  8  per-channel PWM mode select, channels 15..8.
REQ-008 pwm_duty_cycle  input  8  duty cycle shared by all channels, in 1/256 steps.
REQ-009 out  output  16  channel outputs; bit i is channel i.
REQ-010 period_start  output  1  one-clk pulse on the first clk of each PWM period.

Function
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick is asserted while prescaler == CLK_DIV-1 (with CLK_DIV=1, tick is asserted every clk).
REQ-012 8-bit pwm_cnt SHALL increment on tick and wrap from 255 to 0; PWM period is exactly 256*CLK_DIV clks.
REQ-013 Effective duty D SHALL be the duty source per REQ-024/REQ-025.
REQ-014 pwm_sig = 1 when D == 8'hFF, else (pwm_cnt < D); D = 0 gives constant 0, and D = 0xFF gives constant 1 with no one-step low glitch.
REQ-015 Channel logic SHALL be: en_out[i]=0 gives out[i]=0; en_out[i]=1 and en_pwm[i]=0 gives out[i]=1; both set gives out[i]=pwm_sig.
REQ-016 out SHALL be registered, updating one clk after any change in pwm_cnt, enables or D, with no combinational path from inputs to out.
REQ-017 period_start SHALL be registered and high for exactly one clk, in the clk where out reflects pwm_cnt == 0 after a wrap.
REQ-018 Enable changes SHALL take effect immediately (next clk), not deferred to a period boundary.
REQ-019 The block SHALL only consume its inputs; upstream registers are already synchronous to clk and need no synchronizer.

Reset
REQ-020 While rst_n is low, out = 16'h0000, period_start = 0, prescaler = 0, pwm_cnt = 0 and shadow duty = 0.
REQ-021 Reset assertion mid-period SHALL clear all state asynchronously, with no completion of the current period.
REQ-022 After rst_n deassertion, the first tick SHALL occur CLK_DIV clks later, and the period SHALL restart from pwm_cnt = 0.
REQ-023 The first period after reset SHALL NOT assert period_start until the first 255-to-0 wrap.

Configuration
REQ-024 With macro PWM_DUTY_SHADOW_EN defined, pwm_duty_cycle SHALL be captured into the shadow register only on the clk where pwm_cnt wraps 255 to 0 (coincident with tick), and D = shadow; mid-period duty writes SHALL never produce a truncated or double pulse.
REQ-025 Without PWM_DUTY_SHADOW_EN, no shadow register SHALL exist and D = pwm_duty_cycle directly; duty changes SHALL take effect on the next clk.

Verification
REQ-026 Reset: rst_n low for 5 clks with all inputs 0xFF -> out = 0x0000 and period_start = 0 throughout; out = 0xFFFF one clk after release.
REQ-027 Static: en_out = 0x00FF, en_pwm = 0x0000 -> out = 0x00FF constant over 2 periods.
REQ-028 PWM 50%: en_out = 0xFFFF, en_pwm = 0x0001, duty = 0x80, CLK_DIV = 13 -> out[0] high 1664 clks and low 1664 clks per 3328-clk period; out[15:1] = 1.
REQ-029 Extremes: duty = 0x00 -> out[0] never high; duty = 0xFF -> out[0] never low over 2 full periods.
REQ-030 Shadow: with PWM_DUTY_SHADOW_EN, change duty 0x40 to 0xC0 at pwm_cnt = 0x20 -> current period high 64 steps, next period high 192 steps; without the macro -> current period high 192 steps.
REQ-031 Reset mid-period: assert rst_n at pwm_cnt = 0x90 -> out = 0 asynchronously (before the next clk edge); after release, period_start is first seen 256*CLK_DIV clks later.
